// File: rtl/drc_pkg.sv
// Shared definitions for the DVP capture path: capture FSM encoding and bus width default.
package drc_pkg;

    localparam int DVP_DAT_W_DFLT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and occupancy; head visible on rd_dat, 0 cycles to read.
// Write while full is accepted only when a read happens in the same cycle; otherwise it is ignored.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_ok  = wr_en && (!full || rd_en);
    assign rd_ok  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/drc_dvp_pxl_assembler.sv
// Pairs DVP bytes into framed pixels with a frame-last marker; 2 cycles from second byte to o_pxl_vld.
// DVP side cannot stall: a pixel arriving at a full buffer is dropped and flagged (ovf_o).
module drc_dvp_pxl_assembler
    import drc_pkg::*;
#(
    parameter int DVP_DAT_W = DVP_DAT_W_DFLT,
    parameter int I_PXL_W   = 16,
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int BUF_DEPTH = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cap_en_i,
    input  logic [DVP_DAT_W-1:0] dvp_d_i,
    input  logic                 dvp_href_i,
    input  logic                 dvp_vsync_i,
    output logic [I_PXL_W-1:0]   o_pxl_dat,
    output logic                 o_pxl_last,
    output logic                 o_pxl_vld,
    input  logic                 o_pxl_rdy,
    input  logic                 err_clr_i,
    output logic                 ovf_o,
    output logic                 line_err_o,
    output logic                 frame_err_o
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H + 1);
    localparam logic [COL_W-1:0] COL_END  = COL_W'(IMG_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(IMG_H);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    cap_state_e           state_q, state_d;
    logic                 vsync_q, href_q;
    logic                 vsync_rise, vsync_fall, href_fall;
    logic                 phase_q;
    logic [DVP_DAT_W-1:0] b0_q;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic                 push_vld_q, push_last_q;
    logic [I_PXL_W-1:0]   push_dat_q;
    logic [I_PXL_W-1:0]   pix;
    logic                 active, pix_done, row_in, col_in, pix_keep, pix_last, line_chk;
    logic                 pop, fifo_full, fifo_empty;
    logic                 ovf_set, line_err_set, frame_err_set;

    assign vsync_rise = dvp_vsync_i & ~vsync_q;
    assign vsync_fall = ~dvp_vsync_i & vsync_q;
    assign href_fall  = ~dvp_href_i & href_q;

    assign active   = (state_q == ST_ACTIVE);
    assign pix_done = active & dvp_href_i & phase_q;
    assign row_in   = (row_q < ROW_END);
    assign col_in   = (col_q < COL_END);
    assign pix_keep = pix_done & row_in & col_in;
    assign pix_last = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign pix      = MSB_FIRST ? {b0_q, dvp_d_i} : {dvp_d_i, b0_q};
    assign line_chk = active & href_fall & row_in;

    assign pop           = ~fifo_empty & o_pxl_rdy;
    assign ovf_set       = push_vld_q & fifo_full & ~pop;
    assign line_err_set  = (pix_done & row_in & ~col_in)
                         | (line_chk & (phase_q | (col_q != COL_END)));
    // A dropped last pixel means the frame never carries its end marker downstream.
    assign frame_err_set = (pix_done & ~row_in)
                         | (active & vsync_rise & (row_q != ROW_END))
                         | (ovf_set & push_last_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (vsync_rise && cap_en_i) state_d = ST_SYNC;
            ST_SYNC:   if (vsync_fall) state_d = ST_ACTIVE;
            ST_ACTIVE: if (vsync_rise) state_d = cap_en_i ? ST_SYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            // Edge history follows the bus so a level held through reset is not seen as an edge.
            vsync_q     <= dvp_vsync_i;
            href_q      <= dvp_href_i;
            phase_q     <= 1'b0;
            b0_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            push_vld_q  <= 1'b0;
            push_dat_q  <= '0;
            push_last_q <= 1'b0;
            ovf_o       <= 1'b0;
            line_err_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            vsync_q    <= dvp_vsync_i;
            href_q     <= dvp_href_i;
            push_vld_q <= 1'b0;

            if (state_q == ST_SYNC && vsync_fall) begin
                row_q   <= '0;
                col_q   <= '0;
                phase_q <= 1'b0;
            end else if (active && dvp_href_i) begin
                phase_q <= ~phase_q;
                if (!phase_q) begin
                    b0_q <= dvp_d_i;
                end else if (pix_keep) begin
                    push_vld_q  <= 1'b1;
                    push_dat_q  <= pix;
                    push_last_q <= pix_last;
                    col_q       <= col_q + 1'b1;
                end
            end else if (active && href_fall) begin
                if (row_q != ROW_END) begin
                    row_q <= row_q + 1'b1;
                end
                col_q   <= '0;
                phase_q <= 1'b0;
            end

            ovf_o       <= ovf_set       | (ovf_o       & ~err_clr_i);
            line_err_o  <= line_err_set  | (line_err_o  & ~err_clr_i);
            frame_err_o <= frame_err_set | (frame_err_o & ~err_clr_i);
        end
    end

    sync_fifo #(
        .DATA_WIDTH (I_PXL_W + 1),
        .DEPTH      (BUF_DEPTH)
    ) u_fifo (
        .clk    (aclk),
        .rst_n  (aresetn),
        .wr_en  (push_vld_q),
        .wr_dat ({push_last_q, push_dat_q}),
        .rd_en  (pop),
        .rd_dat ({o_pxl_last, o_pxl_dat}),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign o_pxl_vld = ~fifo_empty;

endmodule

// File: tb/tb_drc_dvp_pxl_assembler.sv
module tb_drc_dvp_pxl_assembler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cap_en_i = 1'b0;
    logic [7:0]  dvp_d_i = '0;
    logic        dvp_href_i = 1'b0;
    logic        dvp_vsync_i = 1'b0;
    logic        o_pxl_rdy = 1'b1;
    logic        err_clr_i = 1'b0;

    logic [15:0] pxl_dat, lsb_dat;
    logic        pxl_last, pxl_vld, ovf, line_err, frame_err;
    logic        lsb_last, lsb_vld, lsb_ovf, lsb_line_err, lsb_frame_err;

    int n_chk = 0;
    int n_fail = 0;
    logic [16:0] q_msb[$];
    logic [16:0] q_lsb[$];
    logic [7:0]  nxt_b;

    always #5 aclk = ~aclk;

    drc_dvp_pxl_assembler #(.IMG_W(4), .IMG_H(2), .BUF_DEPTH(4), .MSB_FIRST(1'b1)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .cap_en_i(cap_en_i), .dvp_d_i(dvp_d_i),
        .dvp_href_i(dvp_href_i), .dvp_vsync_i(dvp_vsync_i), .o_pxl_dat(pxl_dat),
        .o_pxl_last(pxl_last), .o_pxl_vld(pxl_vld), .o_pxl_rdy(o_pxl_rdy),
        .err_clr_i(err_clr_i), .ovf_o(ovf), .line_err_o(line_err), .frame_err_o(frame_err)
    );

    drc_dvp_pxl_assembler #(.IMG_W(4), .IMG_H(2), .BUF_DEPTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
        .aclk(aclk), .aresetn(aresetn), .cap_en_i(cap_en_i), .dvp_d_i(dvp_d_i),
        .dvp_href_i(dvp_href_i), .dvp_vsync_i(dvp_vsync_i), .o_pxl_dat(lsb_dat),
        .o_pxl_last(lsb_last), .o_pxl_vld(lsb_vld), .o_pxl_rdy(o_pxl_rdy),
        .err_clr_i(err_clr_i), .ovf_o(lsb_ovf), .line_err_o(lsb_line_err),
        .frame_err_o(lsb_frame_err)
    );

    // Inputs change 1 time unit after posedge, so at negedge the handshake seen is the one taken next edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (pxl_vld && o_pxl_rdy) q_msb.push_back({pxl_last, pxl_dat});
            if (lsb_vld && o_pxl_rdy) q_lsb.push_back({lsb_last, lsb_dat});
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic vpulse();
        dvp_vsync_i = 1'b1;
        step(3);
        dvp_vsync_i = 1'b0;
        step(3);
    endtask

    task automatic send_line(input int len);
        dvp_href_i = 1'b1;
        for (int k = 0; k < len; k++) begin
            dvp_d_i = nxt_b;
            nxt_b   = nxt_b + 8'd1;
            step();
        end
        dvp_href_i = 1'b0;
        dvp_d_i    = '0;
        step(3);
    endtask

    // Frame is opened with cap_en high and closed with cap_en low, leaving the FSM idle.
    task automatic run_frame(input int nlines, input int len, input bit stall);
        nxt_b     = 8'h01;
        cap_en_i  = 1'b1;
        o_pxl_rdy = ~stall;
        vpulse();
        for (int l = 0; l < nlines; l++) send_line(len);
        cap_en_i = 1'b0;
        vpulse();
    endtask

    task automatic clear_errs();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
    endtask

    typedef struct {
        int          nlines;
        int          len;
        bit          stall;
        int          exp_n;
        logic [15:0] exp_first;
        logic [15:0] exp_final;
        logic [15:0] exp_first_lsb;
        int          exp_lasts;
        logic        exp_line;
        logic        exp_frame;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nl;

        vecs[0] = '{2, 8,  1'b0, 8, 16'h0102, 16'h0F10, 16'h0201, 1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2, 7,  1'b0, 6, 16'h0102, 16'h0C0D, 16'h0201, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1, 8,  1'b0, 4, 16'h0102, 16'h0708, 16'h0201, 0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3, 8,  1'b0, 8, 16'h0102, 16'h0F10, 16'h0201, 1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{2, 10, 1'b0, 8, 16'h0102, 16'h1112, 16'h0201, 1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2, 8,  1'b1, 4, 16'h0102, 16'h0708, 16'h0201, 0, 1'b0, 1'b1, 1'b1};

        // Reset state
        step(3);
        chk1("rst_vld", pxl_vld, 1'b0);
        chk1("rst_last", pxl_last, 1'b0);
        chk16("rst_dat", pxl_dat, 16'h0000);
        chk1("rst_ovf", ovf, 1'b0);
        chk1("rst_line_err", line_err, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
        aresetn = 1'b1;
        step(2);

        // Two-cycle latency and byte order on a one-pixel line
        cap_en_i = 1'b1;
        vpulse();
        dvp_href_i = 1'b1;
        dvp_d_i = 8'hA1;
        step();
        dvp_d_i = 8'hB2;
        step();
        dvp_href_i = 1'b0;
        dvp_d_i = '0;
        chk1("lat_vld_early", pxl_vld, 1'b0);
        step();
        chk1("lat_vld", pxl_vld, 1'b1);
        chk16("msb_first_dat", pxl_dat, 16'hA1B2);
        chk16("lsb_first_dat", lsb_dat, 16'hB2A1);
        chk1("short_last", pxl_last, 1'b0);
        step(3);
        cap_en_i = 1'b0;
        vpulse();
        chk1("short_line_err", line_err, 1'b1);
        chk1("short_frame_err", frame_err, 1'b1);
        clear_errs();

        for (int i = 0; i < 6; i++) begin
            q_msb.delete();
            q_lsb.delete();
            run_frame(vecs[i].nlines, vecs[i].len, vecs[i].stall);
            if (vecs[i].stall) begin
                chk1($sformatf("v%0d_stall_vld", i), pxl_vld, 1'b1);
                chk16($sformatf("v%0d_stall_dat0", i), pxl_dat, vecs[i].exp_first);
                step(3);
                chk16($sformatf("v%0d_stall_dat1", i), pxl_dat, vecs[i].exp_first);
                o_pxl_rdy = 1'b1;
            end
            step(10);
            nl = 0;
            foreach (q_msb[k]) if (q_msb[k][16]) nl++;
            chki($sformatf("v%0d_count", i), q_msb.size(), vecs[i].exp_n);
            chk16($sformatf("v%0d_first", i),
                  (q_msb.size() > 0) ? q_msb[0][15:0] : 16'hDEAD, vecs[i].exp_first);
            chk16($sformatf("v%0d_final", i),
                  (q_msb.size() > 0) ? q_msb[$][15:0] : 16'hDEAD, vecs[i].exp_final);
            chk16($sformatf("v%0d_first_lsb", i),
                  (q_lsb.size() > 0) ? q_lsb[0][15:0] : 16'hDEAD, vecs[i].exp_first_lsb);
            chki($sformatf("v%0d_lasts", i), nl, vecs[i].exp_lasts);
            chk1($sformatf("v%0d_last_on_final", i),
                 (q_msb.size() > 0) ? q_msb[$][16] : 1'b0, vecs[i].exp_lasts != 0);
            chk1($sformatf("v%0d_line_err", i), line_err, vecs[i].exp_line);
            chk1($sformatf("v%0d_frame_err", i), frame_err, vecs[i].exp_frame);
            chk1($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
            clear_errs();
            chk1($sformatf("v%0d_clr_line", i), line_err, 1'b0);
            chk1($sformatf("v%0d_clr_frame", i), frame_err, 1'b0);
            chk1($sformatf("v%0d_clr_ovf", i), ovf, 1'b0);
        end

        // Reset in the middle of a line, then a clean frame
        cap_en_i  = 1'b1;
        o_pxl_rdy = 1'b0;
        nxt_b     = 8'h40;
        vpulse();
        dvp_href_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dvp_d_i = nxt_b;
            nxt_b   = nxt_b + 8'd1;
            step();
        end
        step();
        chk1("mid_pre_rst_vld", pxl_vld, 1'b1);
        aresetn = 1'b0;
        step(2);
        chk1("mid_rst_vld", pxl_vld, 1'b0);
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            dvp_d_i = nxt_b;
            nxt_b   = nxt_b + 8'd1;
            step();
        end
        dvp_href_i = 1'b0;
        dvp_d_i    = '0;
        step(3);
        chk1("mid_post_rst_vld", pxl_vld, 1'b0);
        chk1("mid_post_rst_line_err", line_err, 1'b0);
        o_pxl_rdy = 1'b1;
        q_msb.delete();
        run_frame(2, 8, 1'b0);
        step(10);
        chki("after_rst_count", q_msb.size(), 8);
        chk16("after_rst_final", (q_msb.size() > 0) ? q_msb[$][15:0] : 16'hDEAD, 16'h0F10);
        chk1("after_rst_last", (q_msb.size() > 0) ? q_msb[$][16] : 1'b0, 1'b1);
        chk1("after_rst_frame_err", frame_err, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
